// File: rtl/cti8_ctrl_pkg.sv
// cti8_ctrl_pkg: shared control encodings and sequencer state type for the CTI-8 control unit.
package cti8_ctrl_pkg;
    localparam logic [1:0] CTRL_END  = 2'b00;
    localparam logic [1:0] CTRL_NEXT = 2'b01;
    localparam logic [1:0] CTRL_JUMP = 2'b10;
    localparam logic [1:0] CTRL_HOLD = 2'b11;

    typedef enum logic {SEQ_RUN, SEQ_HALT} seq_state_t;
endpackage

// File: rtl/step_decoder.sv
// step_decoder: registered binary-to-one-hot decode of a step value.
module step_decoder #(
    parameter int STEP_W = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [STEP_W-1:0]     step_d,
    output logic [2**STEP_W-1:0]  onehot_q
);
    localparam int N = 2**STEP_W;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) onehot_q <= N'(1);
        else        onehot_q <= N'(1) << step_d;
    end
endmodule

// File: rtl/micro_sequencer.sv
// micro_sequencer: CTI-8 micro-step sequencer with jump/hold, wait stalls,
// boundary-only interrupt entry, halt and a sticky sequencing error flag.
module micro_sequencer
    import cti8_ctrl_pkg::*;
#(
    parameter int STEP_W   = 4,
    parameter int MAX_STEP = 13,
    parameter int IRQ_STEP = 11
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  clk_en,
    input  logic [1:0]            ctrl,
    input  logic [STEP_W-1:0]     jump_step,
    input  logic                  wait_req,
    input  logic                  halt_req,
    input  logic                  irq_req,
    input  logic                  err_clr,
    output logic [STEP_W-1:0]     step,
    output logic [2**STEP_W-1:0]  step_onehot,
    output logic                  fetch_start,
    output logic                  irq_ack,
    output logic                  halted,
    output logic                  err
);
    localparam logic [STEP_W-1:0] MAX_S = STEP_W'(MAX_STEP);
    localparam logic [STEP_W-1:0] IRQ_S = STEP_W'(IRQ_STEP);

    if (MAX_STEP > 2**STEP_W-1) begin : g_bad_max
        $error("MAX_STEP does not fit in STEP_W bits");
    end
    if (IRQ_STEP < 1 || IRQ_STEP > MAX_STEP) begin : g_bad_irq
        $error("IRQ_STEP must lie in 1..MAX_STEP");
    end

    seq_state_t        state_q, state_d;
    logic [STEP_W-1:0] step_q, step_d;
    logic              halted_q, halted_d, err_q, err_d;
    logic              fetch_q, fetch_d, ack_q, ack_d;
    logic              advance, err_set, boundary;

    assign advance = clk_en & ~wait_req;

    always_comb begin
        state_d  = state_q;
        step_d   = step_q;
        halted_d = halted_q;
        fetch_d  = 1'b0;
        ack_d    = 1'b0;
        err_set  = 1'b0;
        boundary = 1'b0;
        if (advance && state_q == SEQ_HALT) begin
            if (!halt_req) begin
                state_d  = SEQ_RUN;
                halted_d = 1'b0;
                fetch_d  = 1'b1;
            end
        end else if (advance) begin
            unique case (ctrl)
                CTRL_NEXT: if (step_q < MAX_S) step_d = step_q + 1'b1;
                           else {err_set, boundary} = 2'b11;
                CTRL_JUMP: if (jump_step <= MAX_S) step_d = jump_step;
                           else {err_set, boundary} = 2'b11;
                CTRL_END:  boundary = 1'b1;
                default:   ;
            endcase
        end
        // halt outranks interrupt, interrupt outranks a plain fetch
        if (boundary) begin
            step_d   = (!halt_req && irq_req) ? IRQ_S : '0;
            state_d  = halt_req ? SEQ_HALT : SEQ_RUN;
            halted_d = halt_req;
            ack_d    = !halt_req && irq_req;
            fetch_d  = !halt_req && !irq_req;
        end
        err_d = err_set | (err_q & ~err_clr);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= SEQ_RUN;
            step_q   <= '0;
            halted_q <= 1'b0;
            err_q    <= 1'b0;
            fetch_q  <= 1'b0;
            ack_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            step_q   <= step_d;
            halted_q <= halted_d;
            err_q    <= err_d;
            fetch_q  <= fetch_d;
            ack_q    <= ack_d;
        end
    end

    step_decoder #(.STEP_W(STEP_W)) u_dec (
        .clk      (clk),
        .rst_n    (rst_n),
        .step_d   (step_d),
        .onehot_q (step_onehot)
    );

    assign step        = step_q;
    assign halted      = halted_q;
    assign err         = err_q;
    assign fetch_start = fetch_q;
    assign irq_ack     = ack_q;
endmodule

// File: tb/tb_micro_sequencer.sv
// tb_micro_sequencer: directed plus randomized checks of micro_sequencer against a behavioural model.
module tb_micro_sequencer;
    import cti8_ctrl_pkg::*;

    localparam int STEP_W = 4;
    localparam int N      = 2**STEP_W;
    localparam int MAXS   = 13;
    localparam int IRQS   = 11;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              clk_en = 1'b0;
    logic [1:0]        ctrl = CTRL_HOLD;
    logic [STEP_W-1:0] jump_step = '0;
    logic              wait_req = 1'b0, halt_req = 1'b0, irq_req = 1'b0, err_clr = 1'b0;
    logic [STEP_W-1:0] step;
    logic [N-1:0]      step_onehot;
    logic              fetch_start, irq_ack, halted, err;

    int n_chk = 0, n_fail = 0;
    int m_step = 0;
    bit m_halt = 0, m_err = 0, m_fs = 0, m_ack = 0, m_e = 0, m_b = 0;

    micro_sequencer #(.STEP_W(STEP_W), .MAX_STEP(MAXS), .IRQ_STEP(IRQS)) dut (
        .clk(clk), .rst_n(rst_n), .clk_en(clk_en), .ctrl(ctrl), .jump_step(jump_step),
        .wait_req(wait_req), .halt_req(halt_req), .irq_req(irq_req), .err_clr(err_clr),
        .step(step), .step_onehot(step_onehot), .fetch_start(fetch_start),
        .irq_ack(irq_ack), .halted(halted), .err(err)
    );

    always #5 clk = ~clk;

    // Reference: what each output must be after an edge, from the sequencing rules.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_step = 0; m_halt = 0; m_err = 0; m_fs = 0; m_ack = 0;
        end else begin
            m_fs = 0; m_ack = 0; m_e = 0; m_b = 0;
            if (clk_en && !wait_req) begin
                if (m_halt) begin
                    if (!halt_req) begin m_halt = 0; m_fs = 1; end
                end else if (ctrl == CTRL_NEXT) begin
                    if (m_step < MAXS) m_step = m_step + 1; else m_e = 1;
                end else if (ctrl == CTRL_JUMP) begin
                    if (int'(jump_step) <= MAXS) m_step = int'(jump_step); else m_e = 1;
                end else if (ctrl == CTRL_END) m_b = 1;
                if (m_e) m_b = 1;
                if (m_b) begin
                    if (halt_req)     begin m_step = 0;    m_halt = 1; end
                    else if (irq_req) begin m_step = IRQS; m_ack = 1;  end
                    else              begin m_step = 0;    m_fs = 1;   end
                end
            end
            if (m_e) m_err = 1;
            else if (err_clr) m_err = 0;
        end
    end

    task automatic chk(string name, int act, int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            chk("model.step", int'(step), m_step);
            chk("model.onehot", int'(step_onehot), 1 << m_step);
            chk("model.fetch_start", int'(fetch_start), int'(m_fs));
            chk("model.irq_ack", int'(irq_ack), int'(m_ack));
            chk("model.halted", int'(halted), int'(m_halt));
            chk("model.err", int'(err), int'(m_err));
        end
    end

    task automatic cyc(logic [1:0] c, int js = 0, bit w = 0, bit h = 0, bit i = 0, bit ec = 0, bit en = 1);
        ctrl = c; jump_step = STEP_W'(js); wait_req = w; halt_req = h;
        irq_req = i; err_clr = ec; clk_en = en;
        @(negedge clk);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        chk("rst.step", int'(step), 0);
        chk("rst.onehot", int'(step_onehot), 1);
        chk("rst.fetch", int'(fetch_start), 0);
        chk("rst.ack", int'(irq_ack), 0);
        chk("rst.halted", int'(halted), 0);
        chk("rst.err", int'(err), 0);

        cyc(CTRL_NEXT); chk("seq.s1", int'(step), 1);
        cyc(CTRL_NEXT); chk("seq.s2", int'(step), 2);
        cyc(CTRL_NEXT); chk("seq.s3", int'(step), 3); chk("seq.nofetch", int'(fetch_start), 0);
        cyc(CTRL_END);  chk("seq.s0", int'(step), 0); chk("seq.fetch", int'(fetch_start), 1);
        chk("seq.err", int'(err), 0);

        cyc(CTRL_NEXT); cyc(CTRL_NEXT);
        for (int k = 0; k < 3; k++) begin
            cyc(CTRL_NEXT, 0, 1); chk("stall.hold2", int'(step), 2);
        end
        cyc(CTRL_NEXT); chk("stall.s3", int'(step), 3);
        cyc(CTRL_HOLD); cyc(CTRL_HOLD); chk("hold.s3", int'(step), 3);
        cyc(CTRL_NEXT, 0, 0, 0, 0, 0, 0); chk("clken.s3", int'(step), 3);

        cyc(CTRL_JUMP, 7);  chk("jump.s7", int'(step), 7);
        cyc(CTRL_JUMP, 14); chk("jump14.s0", int'(step), 0); chk("jump14.err", int'(err), 1);
        cyc(CTRL_HOLD, 0, 0, 0, 0, 1); chk("clr.err", int'(err), 0);
        cyc(CTRL_JUMP, 13); chk("jump.s13", int'(step), 13);
        cyc(CTRL_NEXT); chk("next13.s0", int'(step), 0); chk("next13.err", int'(err), 1);
        cyc(CTRL_HOLD, 0, 0, 0, 0, 1);
        cyc(CTRL_JUMP, 15, 0, 0, 0, 1); chk("clrset.err", int'(err), 1);
        cyc(CTRL_HOLD, 0, 0, 0, 0, 1);

        cyc(CTRL_NEXT); chk("irq.s1", int'(step), 1);
        cyc(CTRL_NEXT, 0, 0, 0, 1); chk("irq.s2", int'(step), 2); chk("irq.noack", int'(irq_ack), 0);
        cyc(CTRL_END, 0, 0, 0, 1);
        chk("irq.s11", int'(step), 11); chk("irq.ack", int'(irq_ack), 1); chk("irq.nofetch", int'(fetch_start), 0);
        cyc(CTRL_HOLD); chk("irq.ack1", int'(irq_ack), 0);

        cyc(CTRL_END, 0, 0, 1, 1);
        chk("halt.s0", int'(step), 0); chk("halt.on", int'(halted), 1); chk("halt.noack", int'(irq_ack), 0);
        cyc(CTRL_NEXT, 0, 0, 1); chk("halt.stay", int'(halted), 1);
        cyc(CTRL_NEXT); chk("halt.off", int'(halted), 0); chk("halt.fetch", int'(fetch_start), 1);
        chk("halt.s0b", int'(step), 0);
        cyc(CTRL_NEXT); chk("halt.s1", int'(step), 1);
        cyc(CTRL_END); cyc(CTRL_END, 0, 0, 0, 0, 0, 0); chk("pulse.once", int'(fetch_start), 0);

        cyc(CTRL_JUMP, 15); cyc(CTRL_JUMP, 5);
        chk("arst.pre_s5", int'(step), 5); chk("arst.pre_err", int'(err), 1);
        ctrl = CTRL_NEXT;
        #2 rst_n = 1'b0;
        #1;
        chk("arst.step", int'(step), 0); chk("arst.onehot", int'(step_onehot), 1);
        chk("arst.err", int'(err), 0); chk("arst.halted", int'(halted), 0);
        @(negedge clk); rst_n = 1'b1;
        cyc(CTRL_NEXT); chk("arst.s1", int'(step), 1); chk("arst.nofetch", int'(fetch_start), 0);

        for (int k = 0; k < 3000; k++) begin
            cyc(2'($urandom_range(0, 3)), int'($urandom_range(0, N-1)),
                $urandom_range(0, 3) == 0, $urandom_range(0, 9) == 0,
                $urandom_range(0, 4) == 0, $urandom_range(0, 9) == 0,
                $urandom_range(0, 4) != 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/micro_sequencer.md
# micro_sequencer

Parametrised micro-step sequencer for the CTI-8 control unit. It generalises the fixed 4-bit END/NEXT step counter with configurable step width and legal step range, plus JUMP/HOLD controls, memory wait stalls, interrupt entry at instruction boundaries, halt, and a sticky error flag in place of simulation-only diagnostics. It sits between the microcode ROM, which drives `ctrl`/`jump_step`, and the control-word decoder, which consumes `step`/`step_onehot`.

## Interface
- `STEP_W`, 4: width of the step counter.
- `MAX_STEP`, 13: highest legal step. Must satisfy `MAX_STEP ≤ 2**STEP_W-1`.
- `IRQ_STEP`, 11: first step of the interrupt-entry microcode. Must satisfy `0 < IRQ_STEP ≤ MAX_STEP`.
- `clk` in 1: system clock, rising edge.
- `rst_n` in 1: reset, asynchronous, active-low.
- `clk_en` in 1: CPU clock enable. The sequencer advances only when `clk_en=1`.
- `ctrl` in 2: step control from microcode. 00 END, 01 NEXT, 10 JUMP, 11 HOLD.
- `jump_step` in STEP_W: target step for JUMP.
- `wait_req` in 1: memory not ready. Stalls the sequencer.
- `halt_req` in 1: request halt at the next instruction boundary.
- `irq_req` in 1: level interrupt request, sampled at instruction boundaries.
- `err_clr` in 1: synchronous clear of `err`.
- `step` out STEP_W: current micro-step.
- `step_onehot` out 2**STEP_W: one-hot decode of `step`.
- `fetch_start` out 1: one-cycle pulse when an instruction fetch begins at step 0.
- `irq_ack` out 1: one-cycle pulse when interrupt entry is taken.
- `halted` out 1: sequencer parked at step 0.
- `err` out 1: sticky illegal-sequencing flag.

## Operation
- Reset values: `step`=0, `step_onehot`=1, `fetch_start`=0, `irq_ack`=0, `halted`=0, `err`=0.
- Advance condition: the sequencer acts on a rising edge with `clk_en=1` and `wait_req=0`. In all other cycles, `step` and `halted` hold.
- Two control states: RUN and HALT.
- RUN, per advance, with `ctrl` decoded:
  - NEXT, `step<MAX_STEP`: `step+1`.
  - NEXT, `step==MAX_STEP`: set `err`, go to the boundary.
  - JUMP, `jump_step≤MAX_STEP`: load `jump_step`.
  - JUMP, `jump_step>MAX_STEP`: set `err`, go to the boundary.
  - HOLD: `step` unchanged.
  - END: go to the boundary.
- Boundary resolution, in priority order:
  1. `halt_req=1`: `step`←0, enter HALT, `halted`←1. No `fetch_start` pulse.
  2. `irq_req=1`: `step`←IRQ_STEP, pulse `irq_ack`.
  3. Otherwise: `step`←0, pulse `fetch_start`.
- HALT: `step` stays 0 and `ctrl` is ignored. On an advance with `halt_req=0`: clear `halted`, return to RUN, pulse `fetch_start`. Steps advance from the next advance onward.
- Interrupts are never taken mid-instruction. `irq_req` is only sampled at a boundary, and is not sampled during HALT exit.
- `err` set and `err_clr` in the same cycle: set wins. `err_clr` is honoured regardless of `clk_en`/`wait_req`.
- Reset asserted mid-instruction: all outputs return to their reset values immediately. The first advance after release executes step 0 with no `fetch_start` pulse.
- Arithmetic: the `step+1` adder is STEP_W wide. Wrap-around is impossible because of the MAX_STEP check.

## Timing
- All outputs are registered. No combinational path from any input to any output.
- `step`, `halted` and `err` update one edge after the qualifying advance, so control latency is 1 cycle.
- `fetch_start` and `irq_ack` are high for exactly one `clk` cycle following the advancing edge, even when `clk_en` is low on the next edge.
- `step_onehot` is registered alongside `step` and always equals the decode of `step`.
- `wait_req` is evaluated in the same cycle as `clk_en`. Asserting it for N enabled cycles delays progress by N enabled cycles.

## Structure
- Shared package `cti8_ctrl_pkg` holds:
  - the `ctrl` encodings `CTRL_END`, `CTRL_NEXT`, `CTRL_JUMP`, `CTRL_HOLD`;
  - the `seq_state_t` enum {`SEQ_RUN`, `SEQ_HALT`}.
- Sub-module `step_decoder`: registered binary-to-one-hot decoder parameterised by STEP_W, reused by the control-word decoder.
- Parameter legality is checked by elaboration-time assertions.

## Test plan
- Reset and sequencing: release reset, `clk_en`=1, `ctrl`=NEXT×3 then END → `step` 0,1,2,3,0; `fetch_start` pulses once as `step` returns to 0; `err`=0.
- Stalls: `step`=2, NEXT with `wait_req`=1 for 3 cycles, then 0 → `step` holds at 2 for 3 cycles, then 3. HOLD at step 3 for 2 cycles → stays 3. `clk_en`=0 → holds.
- JUMP: JUMP with `jump_step`=7 → `step`=7. JUMP with `jump_step`=14 (defaults) → `step`=0, `err`=1. NEXT at `step`=13 → `step`=0, `err`=1. `err_clr`=1 → `err`=0. `err_clr` coincident with a new error → `err` stays 1.
- Interrupt at boundary: `irq_req`=1 raised at step 1, then NEXT, END → `irq_req` ignored until END; then `step`=11, `irq_ack` pulses once, no `fetch_start`.
- Halt: `halt_req`=1 with `irq_req`=1 at END → `step`=0, `halted`=1, no `irq_ack`. Drop `halt_req` → `halted`=0 and `fetch_start` pulses.
- Reset mid-instruction: `rst_n` low at `step`=5 with `err`=1, asynchronously (between edges) → `step`=0, `step_onehot`=1, `err`=0, `halted`=0 before the next clock edge.
